// File: rtl/voice_allocator_pkg.sv
// Shared audio package for the voice allocator.
// Holds FSM encoding, datapath op codes and parameter defaults.
package voice_allocator_pkg;

    localparam int NVOICES_DEF       = 4;
    localparam int NOTE_BITS_DEF     = 7;
    localparam int AGE_BITS_DEF      = 16;
    localparam int RETRIG_CYCLES_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RETRIG = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ALLOC,
        OP_RETRIG,
        OP_STEAL,
        OP_OFF,
        OP_RISE
    } op_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Note-event valid/ready channel into the voice allocator.
// The event source drives master, the allocator takes slave.
interface voice_allocator_if
    import voice_allocator_pkg::*;
#(
    parameter int NOTE_BITS = NOTE_BITS_DEF
) ();

    logic                 ev_valid;
    logic                 ev_ready;
    logic                 ev_on;
    logic [NOTE_BITS-1:0] ev_note;

    modport master (
        output ev_valid,
        output ev_on,
        output ev_note,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_on,
        input  ev_note,
        output ev_ready
    );

endinterface

// File: rtl/voice_allocator_age_select.sv
// Oldest-candidate picker: largest age among masked voices.
// Strict compare keeps the lowest index on ties.
module age_select
    import voice_allocator_pkg::*;
#(
    parameter int NVOICES  = NVOICES_DEF,
    parameter int AGE_BITS = AGE_BITS_DEF,
    localparam int IW      = idx_w(NVOICES)
) (
    input  logic [NVOICES*AGE_BITS-1:0] ages,
    input  logic [NVOICES-1:0]          mask,
    output logic [IW-1:0]               idx,
    output logic                        found
);

    logic [AGE_BITS-1:0] best;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        best  = '0;
        for (int i = 0; i < NVOICES; i++) begin
            if (mask[i] &&
                (!found || ages[i*AGE_BITS +: AGE_BITS] > best)) begin
                idx   = IW'(i);
                found = 1'b1;
                best  = ages[i*AGE_BITS +: AGE_BITS];
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps note events onto envelope gates
// with oldest-voice stealing and a forced gate-low retrigger gap.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NVOICES       = NVOICES_DEF,
    parameter int NOTE_BITS     = NOTE_BITS_DEF,
    parameter int AGE_BITS      = AGE_BITS_DEF,
    parameter int RETRIG_CYCLES = RETRIG_CYCLES_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    voice_allocator_if.slave             ev,
    output logic [NVOICES-1:0]           gate,
    output logic [NVOICES*NOTE_BITS-1:0] voice_note,
    output logic                         stolen
);

    localparam int IW = idx_w(NVOICES);
    localparam logic [AGE_BITS-1:0] AGE_MAX = '1;
    localparam logic [7:0] RLOAD = 8'(RETRIG_CYCLES - 1);

    state_t state, state_n;
    op_t    op;

    logic [IW-1:0]        sel;
    logic [IW-1:0]        tgt;
    logic                 ev_on_q;
    logic [NOTE_BITS-1:0] ev_note_q;
    logic [7:0]           rcnt;

    logic [NVOICES-1:0]   v_gate;
    logic [NOTE_BITS-1:0] v_note [NVOICES];
    logic [AGE_BITS-1:0]  v_age  [NVOICES];

    logic [NVOICES*AGE_BITS-1:0] age_flat;
    logic [NVOICES-1:0]          hit_mask;
    logic [NVOICES-1:0]          free_mask;
    logic [NVOICES-1:0]          sel_oh;

    logic [IW-1:0] m_idx, f_idx, a_idx;
    logic          m_found, f_found, a_found;

    assign ev.ev_ready = (state == IDLE);
    assign free_mask   = ~v_gate;

    always_comb begin
        age_flat = '0;
        hit_mask = '0;
        for (int i = 0; i < NVOICES; i++) begin
            age_flat[i*AGE_BITS +: AGE_BITS] = v_age[i];
            hit_mask[i] = v_gate[i] && (v_note[i] == ev_note_q);
        end
    end

    // Descending scan so the lowest matching index wins.
    always_comb begin
        m_idx   = '0;
        m_found = 1'b0;
        for (int i = NVOICES - 1; i >= 0; i--) begin
            if (hit_mask[i]) begin
                m_idx   = IW'(i);
                m_found = 1'b1;
            end
        end
    end

    age_select #(
        .NVOICES  (NVOICES),
        .AGE_BITS (AGE_BITS)
    ) u_free (
        .ages  (age_flat),
        .mask  (free_mask),
        .idx   (f_idx),
        .found (f_found)
    );

    age_select #(
        .NVOICES  (NVOICES),
        .AGE_BITS (AGE_BITS)
    ) u_act (
        .ages  (age_flat),
        .mask  (v_gate),
        .idx   (a_idx),
        .found (a_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        op      = OP_NONE;
        sel     = '0;
        unique case (state)
            IDLE: begin
                if (ev.ev_valid) state_n = SEARCH;
            end
            SEARCH: begin
                state_n = IDLE;
                if (ev_on_q) begin
                    if (m_found) begin
                        op      = OP_RETRIG;
                        sel     = m_idx;
                        state_n = RETRIG;
                    end else if (f_found) begin
                        op  = OP_ALLOC;
                        sel = f_idx;
                    end else if (a_found) begin
                        op      = OP_STEAL;
                        sel     = a_idx;
                        state_n = RETRIG;
                    end
                end else if (m_found) begin
                    op  = OP_OFF;
                    sel = m_idx;
                end
            end
            RETRIG: begin
                if (rcnt == '0) begin
                    op      = OP_RISE;
                    sel     = tgt;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < NVOICES; i++)
            sel_oh[i] = (op != OP_NONE) && (sel == IW'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_on_q   <= 1'b0;
            ev_note_q <= '0;
            tgt       <= '0;
            rcnt      <= '0;
            stolen    <= 1'b0;
        end else begin
            if (state == IDLE && ev.ev_valid) begin
                ev_on_q   <= ev.ev_on;
                ev_note_q <= ev.ev_note;
            end
            if (op == OP_RETRIG || op == OP_STEAL) begin
                tgt  <= sel;
                rcnt <= RLOAD;
            end else if (state == RETRIG && rcnt != '0) begin
                rcnt <= rcnt - 8'd1;
            end
            stolen <= (op == OP_STEAL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_gate <= '0;
            for (int i = 0; i < NVOICES; i++) begin
                v_note[i] <= '0;
                v_age[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NVOICES; i++) begin
                // Clear beats the saturating increment.
                if (sel_oh[i] &&
                    (op == OP_ALLOC || op == OP_OFF || op == OP_RISE))
                    v_age[i] <= '0;
                else if (v_age[i] != AGE_MAX)
                    v_age[i] <= v_age[i] + 1'b1;
                if (sel_oh[i]) begin
                    case (op)
                        OP_ALLOC: begin
                            v_gate[i] <= 1'b1;
                            v_note[i] <= ev_note_q;
                        end
                        OP_STEAL: begin
                            v_gate[i] <= 1'b0;
                            v_note[i] <= ev_note_q;
                        end
                        OP_RETRIG: v_gate[i] <= 1'b0;
                        OP_OFF:    v_gate[i] <= 1'b0;
                        OP_RISE:   v_gate[i] <= 1'b1;
                        default:   ;
                    endcase
                end
            end
        end
    end

    // Output stage: a register copy of the voice table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate       <= '0;
            voice_note <= '0;
        end else begin
            gate <= v_gate;
            for (int i = 0; i < NVOICES; i++)
                voice_note[i*NOTE_BITS +: NOTE_BITS] <= v_note[i];
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios plus random events
// checked against an event-level allocation model.
module tb_voice_allocator;

    localparam int NV   = 4;
    localparam int NB   = 7;
    localparam int AB   = 5;
    localparam int RC   = 8;
    localparam int AMAX = (1 << AB) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NV-1:0]   gate;
    logic [NV*NB-1:0] voice_note;
    logic            stolen;

    voice_allocator_if #(.NOTE_BITS(NB)) evif ();

    voice_allocator #(
        .NVOICES       (NV),
        .NOTE_BITS     (NB),
        .AGE_BITS      (AB),
        .RETRIG_CYCLES (RC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ev         (evif),
        .gate       (gate),
        .voice_note (voice_note),
        .stolen     (stolen)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int nstolen = 0;
    int lowrun [NV];
    int lastrun [NV];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (stolen === 1'b1) nstolen <= nstolen + 1;

    // Length of the most recent completed gate-low run, per voice.
    always @(negedge clk) begin
        for (int i = 0; i < NV; i++) begin
            if (gate[i] !== 1'b1) lowrun[i] <= lowrun[i] + 1;
            else begin
                if (lowrun[i] != 0) lastrun[i] <= lowrun[i];
                lowrun[i] <= 0;
            end
        end
    end

    // Reference model: per-voice gate, note and the edge of last age clear.
    bit mgate [NV];
    int mnote [NV];
    int tclr  [NV];
    int base;
    int st_base;
    int exp_steals;

    function automatic int mage(input int v, input int t);
        int d;
        d = t - tclr[v];
        return (d > AMAX) ? AMAX : d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        evif.ev_valid = 1'b0;
        evif.ev_on    = 1'b0;
        evif.ev_note  = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            mgate[i] = 1'b0;
            mnote[i] = 0;
            tclr[i]  = 0;
        end
        exp_steals = 0;
        rst_n   = 1'b1;
        base    = cyc;
        st_base = nstolen;
    endtask

    task automatic send(input bit on, input int note, input bit hold);
        int acc, d, busy, exp_busy, m, b;
        chk("ready_idle", 32'(evif.ev_ready), 32'd1);
        evif.ev_valid = 1'b1;
        evif.ev_on    = on;
        evif.ev_note  = NB'(note);
        @(posedge clk);
        #1;
        acc  = cyc - base;
        busy = 0;
        do begin
            @(negedge clk);
            busy++;
        end while (evif.ev_ready !== 1'b1 && busy < 300);
        if (!hold) evif.ev_valid = 1'b0;
        d = acc + 1;
        m = -1;
        for (int i = NV - 1; i >= 0; i--)
            if (mgate[i] && mnote[i] == note) m = i;
        exp_busy = 2;
        if (on) begin
            if (m >= 0) begin
                tclr[m]  = d + RC;
                exp_busy = RC + 2;
            end else begin
                b = -1;
                for (int i = 0; i < NV; i++)
                    if (!mgate[i] && (b < 0 || mage(i, acc) > mage(b, acc)))
                        b = i;
                if (b >= 0) begin
                    mgate[b] = 1'b1;
                    mnote[b] = note;
                    tclr[b]  = d;
                end else begin
                    for (int i = 0; i < NV; i++)
                        if (b < 0 || mage(i, acc) > mage(b, acc)) b = i;
                    mnote[b] = note;
                    tclr[b]  = d + RC;
                    exp_busy = RC + 2;
                    exp_steals++;
                end
            end
        end else if (m >= 0) begin
            mgate[m] = 1'b0;
            tclr[m]  = d;
        end
        chk("busy_cycles", 32'(busy), 32'(exp_busy));
    endtask

    task automatic cmp_model();
        logic [31:0] eg, en;
        @(negedge clk);
        #1;
        eg = '0;
        en = '0;
        for (int i = 0; i < NV; i++) begin
            eg[i] = mgate[i];
            en[i*NB +: NB] = NB'(mnote[i]);
        end
        chk("gate", 32'(gate), eg);
        chk("voice_note", 32'(voice_note), en);
        chk("steal_count", 32'(nstolen - st_base), 32'(exp_steals));
    endtask

    logic [NV-1:0]    g_keep;
    logic [NV*NB-1:0] n_keep;

    initial begin
        for (int i = 0; i < NV; i++) begin
            lowrun[i]  = 0;
            lastrun[i] = 0;
        end
        rst_n = 1'b0;
        evif.ev_valid = 1'b0;
        evif.ev_on    = 1'b0;
        evif.ev_note  = '0;
        @(negedge clk);
        #1;
        chk("rst_gate", 32'(gate), 32'd0);
        chk("rst_note", 32'(voice_note), 32'd0);
        chk("rst_stolen", 32'(stolen), 32'd0);
        do_reset();
        @(negedge clk);
        chk("ready_after_rst", 32'(evif.ev_ready), 32'd1);

        // Single note on then off, with latency check.
        send(1'b1, 60, 1'b0);
        chk("lat_pre", 32'(gate), 32'd0);
        cmp_model();
        chk("on60_gate", 32'(gate), 32'b0001);
        chk("on60_note", 32'(voice_note[NB-1:0]), 32'd60);
        send(1'b0, 60, 1'b0);
        cmp_model();
        chk("off60_gate", 32'(gate), 32'b0000);

        // Fill all voices then steal the oldest.
        do_reset();
        send(1'b1, 60, 1'b0); cmp_model();
        send(1'b1, 62, 1'b0); cmp_model();
        send(1'b1, 64, 1'b0); cmp_model();
        send(1'b1, 65, 1'b0); cmp_model();
        send(1'b1, 67, 1'b0); cmp_model();
        chk("steal_gate", 32'(gate), 32'b1111);
        chk("steal_note0", 32'(voice_note[NB-1:0]), 32'd67);
        chk("steal_low_run", 32'(lastrun[0]), 32'(RC));
        chk("steal_pulses", 32'(nstolen - st_base), 32'd1);

        // Retrigger of a held note keeps the note.
        send(1'b1, 62, 1'b0); cmp_model();
        chk("retrig_low_run", 32'(lastrun[1]), 32'(RC));
        chk("retrig_note1", 32'(voice_note[NB +: NB]), 32'd62);

        // Note-off for an absent note changes nothing.
        g_keep = gate;
        n_keep = voice_note;
        send(1'b0, 50, 1'b0); cmp_model();
        chk("off50_gate", 32'(gate), 32'(g_keep));
        chk("off50_note", 32'(voice_note), 32'(n_keep));

        // ev_valid held high across back-to-back events.
        do_reset();
        send(1'b1, 40, 1'b1);
        send(1'b1, 41, 1'b1);
        send(1'b1, 40, 1'b1);
        send(1'b1, 42, 1'b0);
        cmp_model();
        chk("hold_gate", 32'(gate), 32'b0111);

        // Reset in the middle of a steal retrigger.
        do_reset();
        send(1'b1, 60, 1'b0); cmp_model();
        send(1'b1, 62, 1'b0); cmp_model();
        send(1'b1, 64, 1'b0); cmp_model();
        send(1'b1, 65, 1'b0); cmp_model();
        evif.ev_valid = 1'b1;
        evif.ev_on    = 1'b1;
        evif.ev_note  = NB'(67);
        @(posedge clk);
        #1;
        evif.ev_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_gate", 32'(gate), 32'd0);
        chk("abort_ready", 32'(evif.ev_ready), 32'd1);
        do_reset();
        repeat (12) @(negedge clk);
        chk("abort_no_rise", 32'(gate), 32'd0);
        send(1'b1, 70, 1'b0); cmp_model();
        chk("abort_next_gate", 32'(gate), 32'b0001);
        chk("abort_next_note", 32'(voice_note[NB-1:0]), 32'd70);

        // Random events over a small note range.
        do_reset();
        for (int k = 0; k < 80; k++) begin
            bit on, hold;
            int note;
            on   = ($urandom_range(0, 9) < 7);
            note = 60 + $urandom_range(0, 5);
            hold = (k != 79) && ($urandom_range(0, 3) == 0);
            send(on, note, hold);
            if (!hold) begin
                cmp_model();
                repeat ($urandom_range(0, 40)) @(negedge clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
